// File: rtl/tt_mem_elem_gen.sv
// Turns the credited mask/index item stream into per-element LSU requests for one
// strided or indexed vector memop, returning one credit for every item popped.
module tt_mem_elem_gen #(
   parameter int VLEN         = 256,
   parameter int MASK_CREDITS = 2
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic                       i_start,
   input  logic                       i_is_indexed,
   input  logic                       i_is_masked,
   input  logic [$clog2(VLEN+1)-1:0]  i_vl,
   input  logic [63:0]                i_base_addr,
   input  logic [63:0]                i_stride,
   input  logic                       i_mask_idx_valid,
   input  logic [64:0]                i_mask_idx_item,
   input  logic                       i_mask_idx_last_idx,
   output logic                       o_mask_idx_credit,
   output logic                       o_req_valid,
   input  logic                       i_req_ready,
   output logic [63:0]                o_req_addr,
   output logic [$clog2(VLEN)-1:0]    o_req_elem,
   output logic                       o_req_last,
   output logic                       o_busy,
   output logic                       o_done
);
   localparam int VLW = $clog2(VLEN+1);
   localparam int EW  = $clog2(VLEN);
   localparam int PW  = (MASK_CREDITS > 1) ? $clog2(MASK_CREDITS) : 1;
   localparam int CW  = $clog2(MASK_CREDITS+1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
   state_t r_state, w_state_nxt;

   logic            r_is_indexed, r_is_masked, r_credit;
   logic [VLW-1:0]  r_vl, r_e, r_exp, r_popped;
   logic [63:0]     r_base, r_stride, r_addr;
   logic [64:0]     r_mem [MASK_CREDITS];
   logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]   r_count;

   logic            w_empty, w_full, w_push, w_pop, w_step, w_req_valid, w_en;
   logic            w_is_last_e, w_word_end;
   logic [64:0]     w_head;
   logic [63:0]     w_word;
   logic [VLW:0]    w_words_wide;
   logic [VLW-1:0]  w_words, w_exp_start;

   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == CW'(MASK_CREDITS));
   assign w_push      = i_mask_idx_valid && !w_full;
   assign w_head      = r_mem[r_rd_ptr];
   assign w_word      = w_head[63:0];
   assign w_is_last_e = (r_e == r_vl - VLW'(1));
   assign w_word_end  = (r_e[5:0] == 6'd63) || w_is_last_e;

   // Mask words needed for a masked strided op; vl=0 still carries one word.
   assign w_words_wide = ({1'b0, i_vl} + (VLW+1)'(63)) >> 6;
   assign w_words      = w_words_wide[VLW-1:0];
   assign w_exp_start  = i_is_indexed ? i_vl :
                         i_is_masked  ? ((w_words == '0) ? VLW'(1) : w_words) : '0;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MASK_CREDITS-1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_step      = 1'b0;
      w_req_valid = 1'b0;
      w_en        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_state_nxt = (i_vl == '0) ? S_DRAIN : S_RUN;
         end
         S_RUN: begin
            if (r_is_indexed) begin
               if (!w_empty) begin
                  w_en        = r_is_masked ? w_head[64] : 1'b1;
                  w_req_valid = w_en;
                  w_step      = w_en ? i_req_ready : 1'b1;
                  w_pop       = w_step;
               end
            end else if (r_is_masked) begin
               if (!w_empty) begin
                  w_en        = w_word[r_e[5:0]];
                  w_req_valid = w_en;
                  w_step      = w_en ? i_req_ready : 1'b1;
                  w_pop       = w_step && w_word_end;
               end
            end else begin
               w_en        = 1'b1;
               w_req_valid = 1'b1;
               w_step      = i_req_ready;
            end
            if (w_step && w_is_last_e) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (r_popped == r_exp) w_state_nxt = S_DONE;
            else if (!w_empty)     w_pop       = 1'b1;
         end
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state      <= S_IDLE;
         r_is_indexed <= 1'b0;
         r_is_masked  <= 1'b0;
         r_credit     <= 1'b0;
         r_vl         <= '0;
         r_e          <= '0;
         r_exp        <= '0;
         r_popped     <= '0;
         r_base       <= '0;
         r_stride     <= '0;
         r_addr       <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_credit <= w_pop;
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_mask_idx_item;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_popped <= r_popped + VLW'(1);
         end
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CW'(1);
         if (r_state == S_IDLE && i_start) begin
            r_is_indexed <= i_is_indexed;
            r_is_masked  <= i_is_masked;
            r_vl         <= i_vl;
            r_base       <= i_base_addr;
            r_stride     <= i_stride;
            r_addr       <= i_base_addr;
            r_e          <= '0;
            r_exp        <= w_exp_start;
            r_popped     <= '0;
         end else if (w_step) begin
            r_e    <= r_e + VLW'(1);
            r_addr <= r_addr + r_stride;
         end
      end
   end

   assign o_mask_idx_credit = r_credit;
   assign o_req_valid       = w_req_valid;
   assign o_req_addr        = !w_req_valid ? 64'd0 :
                              r_is_indexed ? r_base + w_head[63:0] : r_addr;
   assign o_req_elem        = w_req_valid ? r_e[EW-1:0] : '0;
   assign o_req_last        = w_req_valid && w_is_last_e;
   assign o_busy            = (r_state != S_IDLE);
   assign o_done            = (r_state == S_DONE);

   // Upstream may only send while holding a credit; the FIFO never overflows.
   a_no_push_full: assert property (@(posedge i_clk) disable iff (!i_reset_n)
      !(i_mask_idx_valid && w_full));
   a_last_has_valid: assert property (@(posedge i_clk) disable iff (!i_reset_n)
      i_mask_idx_last_idx |-> i_mask_idx_valid);
endmodule
